// File: rtl/sample_word_packer_if.sv
// Sample-in / word-out handshake bundle for sample_word_packer.
// The slave modport is the packer; the master modport is the sample source plus the word sink.
interface sample_word_packer_if;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;

  modport master (
    output sample_valid, sample, word_ready,
    input  word_valid, word_data
  );

  modport slave (
    input  sample_valid, sample, word_ready,
    output word_valid, word_data
  );
endinterface

// File: rtl/sample_word_packer.sv
// Packs four 8-bit channel samples into a 32-bit word and buffers the words in a
// circular first-word-fall-through FIFO that feeds the FX3 slave-FIFO write engine.
module sample_word_packer #(
  parameter int DEPTH_LOG2   = 11,
  parameter int PACKET_WORDS = 1024
) (
  input  logic                  clk_pll,
  input  logic                  reset_,
  input  logic                  clear,
  input  logic                  enable,
  sample_word_packer_if.slave   bus,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  packet_avail,
  output logic                  overflow,
  output logic [15:0]           dropped_count
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PKT_LVL  = (DEPTH_LOG2+1)'(PACKET_WORDS);
  localparam logic [DEPTH_LOG2:0] ONE_LVL  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                  flush;
  logic                  accept;
  logic [1:0]            lane_p0;
  logic [23:0]           pack_p0;
  logic                  vld_p0;
  logic [31:0]           word_p0;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   ram_count;
  logic [DEPTH_LOG2:0]   fill_next;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  logic                  load;

  assign flush  = !reset_ || clear;
  assign accept = enable && bus.sample_valid;

  // Packer stage: lanes 0..2 are held here, lane 3 completes the word combinationally.
  assign vld_p0  = accept && (lane_p0 == 2'd3);
  assign word_p0 = {bus.sample, pack_p0};

  always_ff @(posedge clk_pll) begin
    if (flush || !enable) begin
      lane_p0 <= 2'd0;
    end else if (accept) begin
      lane_p0 <= lane_p0 + 2'd1;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (accept) begin
      case (lane_p0)
        2'd0:    pack_p0[7:0]   <= bus.sample;
        2'd1:    pack_p0[15:8]  <= bus.sample;
        2'd2:    pack_p0[23:16] <= bus.sample;
        default: pack_p0        <= pack_p0;
      endcase
    end
  end

  // FIFO stage: fill_level counts the RAM contents plus the output register.
  assign pop       = bus.word_valid && bus.word_ready;
  assign full      = (fill_level == FULL_LVL);
  assign ram_count = fill_level - {{DEPTH_LOG2{1'b0}}, bus.word_valid};
  assign wr_en     = !flush && vld_p0 && (!full || pop);
  assign drop      = vld_p0 && full && !pop;
  assign load      = (ram_count != '0) && (!bus.word_valid || pop);

  always_comb begin
    fill_next = fill_level;
    case ({wr_en, pop})
      2'b10:   fill_next = fill_level + ONE_LVL;
      2'b01:   fill_next = fill_level - ONE_LVL;
      default: fill_next = fill_level;
    endcase
  end

  always_ff @(posedge clk_pll) begin
    if (wr_en) begin
      mem[wr_ptr] <= word_p0;
    end
  end

  // Output stage: registered head word, refilled whenever it empties or is popped.
  always_ff @(posedge clk_pll) begin
    if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.word_valid <= 1'b0;
      bus.word_data  <= 32'd0;
      fill_level     <= '0;
      packet_avail   <= 1'b0;
      overflow       <= 1'b0;
      dropped_count  <= 16'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (load) begin
        rd_ptr         <= rd_ptr + ONE_PTR;
        bus.word_valid <= 1'b1;
        bus.word_data  <= mem[rd_ptr];
      end else if (pop) begin
        bus.word_valid <= 1'b0;
      end
      fill_level   <= fill_next;
      packet_avail <= (fill_next >= PKT_LVL);
      if (drop) begin
        overflow      <= 1'b1;
        dropped_count <= sat_inc16(dropped_count);
      end
    end
  end

endmodule

// File: tb/tb_sample_word_packer.sv
// Directed bench for sample_word_packer: latency, partial-word discard, overflow,
// full-with-pop, stall stability under random ready, clear and reset mid-word.
module tb_sample_word_packer;

  logic        clk_pll = 1'b0;
  logic        reset_;
  logic        clear;
  logic        enable;
  logic [11:0] fill_level;
  logic        packet_avail;
  logic        overflow;
  logic [15:0] dropped_count;

  always #5 clk_pll = ~clk_pll;

  sample_word_packer_if bus();

  sample_word_packer #(.DEPTH_LOG2(11), .PACKET_WORDS(1024)) dut (
    .clk_pll       (clk_pll),
    .reset_        (reset_),
    .clear         (clear),
    .enable        (enable),
    .bus           (bus),
    .fill_level    (fill_level),
    .packet_avail  (packet_avail),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  logic        mon_en     = 1'b0;
  logic        stall_en   = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Popped words are recorded half a cycle before the edge that pops them.
  always @(negedge clk_pll) begin
    if (mon_en && reset_ && !clear && bus.word_valid && bus.word_ready)
      got.push_back(bus.word_data);
    if (stall_en) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("stall_data", bus.word_data, prev_data);
      end
      prev_stall = bus.word_valid && !bus.word_ready;
      prev_data  = bus.word_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.sample_valid = 1'b1;
    bus.sample       = b;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) put(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    bus.sample_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    bus.sample_valid = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (fill_level == 12'd0 && !bus.word_valid) break;
      tick();
    end
    chk(tag, {20'd0, fill_level}, 32'd0);
  endtask

  task automatic cmp_q(input string tag);
    int bad;
    bad = -1;
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int j = 0; j < got.size() && j < exp_q.size(); j++) begin
      if (bad < 0 && got[j] !== exp_q[j]) bad = j;
    end
    chk({tag, "_first_bad_index"}, bad, 32'hFFFF_FFFF);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.word_valid}, 32'd0);
    chk({tag, "_data"}, bus.word_data, 32'd0);
    chk({tag, "_fill"}, {20'd0, fill_level}, 32'd0);
    chk({tag, "_pavail"}, {31'd0, packet_avail}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_dropped"}, {16'd0, dropped_count}, 32'd0);
  endtask

  initial begin
    reset_ = 1'b0; clear = 1'b0; enable = 1'b0;
    bus.sample_valid = 1'b0; bus.sample = 8'h00; bus.word_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_zero("reset");

    // First word latency with the sink always ready.
    reset_ = 1'b1; enable = 1'b1; bus.word_ready = 1'b1;
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    chk("lat_fill_k", {20'd0, fill_level}, 32'd1);
    chk("lat_valid_k", {31'd0, bus.word_valid}, 32'd0);
    idle(1);
    chk("lat_valid_k1", {31'd0, bus.word_valid}, 32'd1);
    chk("lat_data_k1", bus.word_data, 32'h04030201);
    tick();
    chk("lat_valid_k2", {31'd0, bus.word_valid}, 32'd0);
    chk("lat_fill_k2", {20'd0, fill_level}, 32'd0);
    chk("lat_data_hold", bus.word_data, 32'h04030201);

    // Partial word discarded by enable low.
    got.delete(); mon_en = 1'b1;
    put(8'h11); put(8'h22); put(8'h33);
    enable = 1'b0; bus.sample_valid = 1'b0; tick();
    enable = 1'b1;
    put(8'h44); put(8'h55); put(8'h66); put(8'h77);
    idle(4);
    exp_q.delete(); exp_q.push_back(32'h77665544);
    cmp_q("partial");
    mon_en = 1'b0;

    // Fill to capacity with the sink stalled, then one dropped word.
    do_clear();
    bus.word_ready = 1'b0;
    for (int n = 0; n < 2048; n++) begin
      send_word(n);
      if (n == 1022) chk("pavail_below", {31'd0, packet_avail}, 32'd0);
      if (n == 1023) begin
        chk("pavail_at", {31'd0, packet_avail}, 32'd1);
        chk("fill_at_pkt", {20'd0, fill_level}, 32'd1024);
      end
    end
    chk("full_fill", {20'd0, fill_level}, 32'd2048);
    chk("full_no_ovf", {31'd0, overflow}, 32'd0);
    send_word(32'd2048);
    chk("ovf_fill", {20'd0, fill_level}, 32'd2048);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_dropped", {16'd0, dropped_count}, 32'd1);

    // Push and pop at the same edge while full, then drain across the pointer wrap.
    got.delete(); mon_en = 1'b1;
    put(8'h01); put(8'h08); put(8'h00);
    bus.word_ready = 1'b1;
    put(8'h00);
    chk("fullpop_fill", {20'd0, fill_level}, 32'd2048);
    chk("fullpop_dropped", {16'd0, dropped_count}, 32'd1);
    drain("fullpop_drain", 2200);
    exp_q.delete();
    for (int j = 0; j < 2048; j++) exp_q.push_back(j);
    exp_q.push_back(32'd2049);
    cmp_q("wrap_order");
    mon_en = 1'b0;

    // Random back-pressure: stalled word must hold, every word popped once in order.
    do_clear();
    got.delete(); mon_en = 1'b1; stall_en = 1'b1;
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      exp_q.push_back(32'h5000_0000 + n);
      for (int i = 0; i < 4; i++) begin
        bus.word_ready = 1'($urandom_range(0, 1));
        put(8'((32'h5000_0000 + n) >> (8*i)));
      end
    end
    bus.sample_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (fill_level == 12'd0 && !bus.word_valid) break;
      bus.word_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_drain", {20'd0, fill_level}, 32'd0);
    cmp_q("rand_order");
    stall_en = 1'b0; mon_en = 1'b0;

    // Clear with the FIFO half full, overflow set and five drops, mid-word.
    do_clear();
    bus.word_ready = 1'b0;
    for (int n = 0; n < 2053; n++) send_word(n);
    chk("pre_clear_dropped", {16'd0, dropped_count}, 32'd5);
    bus.word_ready = 1'b1;
    idle(1024);
    bus.word_ready = 1'b0;
    chk("pre_clear_fill", {20'd0, fill_level}, 32'd1024);
    chk("pre_clear_ovf", {31'd0, overflow}, 32'd1);
    put(8'hE1); put(8'hE2);
    clear = 1'b1; bus.sample_valid = 1'b1; bus.sample = 8'hE3; tick();
    clear = 1'b0;
    chk_zero("clear");
    got.delete(); mon_en = 1'b1; bus.word_ready = 1'b1;
    put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
    idle(4);
    exp_q.delete(); exp_q.push_back(32'hA4A3A2A1);
    cmp_q("after_clear");

    // Reset mid-word: only post-reset samples form the next word.
    got.delete();
    put(8'hC1); put(8'hC2);
    reset_ = 1'b0; bus.sample_valid = 1'b0; tick();
    reset_ = 1'b1;
    put(8'hB1); put(8'hB2); put(8'hB3); put(8'hB4);
    idle(4);
    exp_q.delete(); exp_q.push_back(32'hB4B3B2B1);
    cmp_q("after_reset");
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_word_packer.md
# sample_word_packer

Capture-side buffer that sits directly upstream of the FX3 slave-FIFO write engine. It takes the 8-bit per-cycle channel sample stream (one bit per logic-analyser channel, CH0 in bit 7), packs four consecutive samples into 32-bit words, and stores them in a circular word FIFO. The write engine drains the FIFO with a valid/ready handshake and uses `packet_avail` to start a full FX3 burst only when one packet of data is already buffered.

## Interface
- `DEPTH_LOG2`, default 11: FIFO depth is 2^DEPTH_LOG2 words (2048).
- `PACKET_WORDS`, default 1024: words per FX3 packet; threshold for `packet_avail`. Must be ≤ 2^DEPTH_LOG2.
- `clk_pll`  in  1  system clock (100 MHz domain shared with the FX3 interface).
- `reset_`  in  1  reset; synchronous, active-low.
- `clear`  in  1  synchronous flush of packer, FIFO, counters and flags.
- `enable`  in  1  capture enable; samples are ignored while low.
- `sample_valid`  in  1  `sample` is presented this cycle.
- `sample`  in  8  channel bits, CH0 = bit 7 … CH7 = bit 0.
- `word_ready`  in  1  write engine accepts `word_data` this cycle.
- `word_valid`  out  1  `word_data` holds the FIFO head word.
- `word_data`  out  32  packed word; oldest sample in [7:0], newest in [31:24].
- `fill_level`  out  DEPTH_LOG2+1  words stored, including the output register.
- `packet_avail`  out  1  `fill_level >= PACKET_WORDS`.
- `overflow`  out  1  sticky; a packed word was dropped because the FIFO was full.
- `dropped_count`  out  16  dropped words, saturating at 16'hFFFF.

## Operation
- Reset (`reset_` low at an edge) and `clear` high at an edge have the same effect, and reset has priority. All outputs go to 0: `word_valid`, `word_data`, `fill_level`, `packet_avail`, `overflow`, `dropped_count`. The byte counter and the read/write pointers also go to 0. Stored data is discarded.
- Packer:
  - A sample is accepted at an edge where `enable & sample_valid` is high.
  - A 2-bit byte counter selects the lane: 0 selects [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
  - Accepting the sample at lane 3 completes a word and produces a push request. The counter then wraps to 0.
  - When `enable` is sampled low, the byte counter is reset to 0 and any partial word is discarded. It is never pushed.
- FIFO: circular RAM with DEPTH_LOG2-bit pointers. Storage is first-word-fall-through, with a registered output stage.
  - Full means `fill_level == 2^DEPTH_LOG2` before the edge.
  - A push while full with no pop at the same edge drops the word. `overflow` is set and `dropped_count` increments with saturation. The pointers do not change.
  - A push while full with a simultaneous pop is accepted and `fill_level` is unchanged.
  - A pop occurs at an edge where `word_valid & word_ready` is high. `word_ready` while `word_valid` is low is ignored.
  - A push and a pop at the same edge leave `fill_level` unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2 with no gap.
- Output register:
  - Loads the next head word whenever it is empty or popped and the RAM holds data.
  - `word_data` is held stable while `word_valid & !word_ready`.
  - `word_data` keeps its last value after `word_valid` falls.
- `packet_avail` and `fill_level` are registered and are updated at the same edge as the push or pop that changes them.

## Timing
- A sample completing a word at edge k is written to RAM at edge k. It appears in `fill_level` after edge k.
- If the FIFO was otherwise empty, `word_valid` rises after edge k+1.
- Back-to-back pops: with `word_ready` held high and data stored, one word is delivered per cycle with no bubbles. This is sustained throughput of one word per clock.
- A sample presented every cycle produces one push every 4 cycles.
- `clear` has priority over a simultaneous push and pop. After a `clear` edge all state is as after reset. Samples accepted during the clear cycle are discarded.
- Reset asserted mid-word or mid-drain discards everything. The first word after reset is formed only from samples accepted after reset is released.

## Test plan
- Reset release, then samples 8'h01, 8'h02, 8'h03, 8'h04 on consecutive cycles with `word_ready` high. Expect `word_valid` high 2 cycles after the 4th sample, with `word_data` = 32'h04030201 for 1 cycle, and `fill_level` back to 0.
- Samples 11, 22, 33 accepted, then `enable` low for 1 cycle, then 44, 55, 66, 77. Expect exactly one word, 32'h77665544. The partial word is discarded.
- `word_ready` low and 4×2048 samples, then 4 more. Expect `fill_level` = 2048, `overflow` = 1, `dropped_count` = 1, with `packet_avail` having risen at `fill_level` = 1024.
- FIFO full with `word_ready` high and a word completing at the same edge. Expect the word to be accepted, `fill_level` to stay at 2048, and `dropped_count` unchanged. Also expect data order across the pointer wrap to be preserved: the sequence is incrementing, so a scoreboard shows no gaps.
- `word_valid` high and `word_ready` toggling randomly. Expect `word_data` stable while stalled and each word popped exactly once, in order.
- `clear` pulsed with the FIFO half full, `overflow` = 1 and `dropped_count` = 5. On the next cycle expect all outputs to be 0, followed by normal capture with the first word = the next 4 samples.
